// File: rtl/vga_sprite_engine.sv
// Draws one movable, rotatable SPR_SIZE x SPR_SIZE sprite from an external 1-cycle ROM over a flat background.
// Coordinates to RGB take 2 clocks with no backpressure. Define VGA_SPRITE_BTN_SYNC_EN to synchronise and qualify the buttons.
module vga_sprite_engine #(
    parameter int          H_PIXELS  = 640,
    parameter int          V_PIXELS  = 480,
    parameter int          SPR_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          WRAP_EN   = 0,
    parameter logic [11:0] BG_COLOUR = 12'hFFF,
    parameter logic [11:0] TRANS_KEY = 12'hF0F,
    parameter int          ADDR_W    = 10
) (
    input  logic              Master_Clock_In,
    input  logic              Reset_N_In,
    input  logic              Disp_Ena_In,
    input  logic [9:0]        Val_Col_In,
    input  logic [9:0]        Val_Row_In,
    input  logic              Up,
    input  logic              Down,
    input  logic              Left,
    input  logic              Right,
    output logic [ADDR_W-1:0] Rom_Addr_Out,
    input  logic [11:0]       Rom_Data_In,
    output logic [3:0]        Red,
    output logic [3:0]        Green,
    output logic [3:0]        Blue,
    output logic              Sprite_Hit_Out,
    output logic [9:0]        X_Pos_Out,
    output logic [9:0]        Y_Pos_Out,
    output logic              Frame_Tick_Out
);
    typedef enum logic [1:0] {WAIT_FRAME, UPDATE, WAIT_ACTIVE} frame_state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic signed [10:0] MAX_X  = 11'(H_PIXELS - SPR_SIZE);
    localparam logic signed [10:0] MAX_Y  = 11'(V_PIXELS - SPR_SIZE);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] SPR_S  = 11'(SPR_SIZE);
    localparam logic signed [10:0] S_MAX  = 11'(SPR_SIZE - 1);
    localparam logic [10:0]        H_LIM  = 11'(H_PIXELS);
    localparam logic [10:0]        V_LIM  = 11'(V_PIXELS);
    localparam logic [9:0]         X_INIT = 10'((H_PIXELS - SPR_SIZE) / 2);
    localparam logic [9:0]         Y_INIT = 10'((V_PIXELS - SPR_SIZE) / 2);

    frame_state_t state, state_nxt;
    dir_t         dir, dir_nxt;
    logic [9:0]   x_pos, y_pos, x_nxt, y_nxt;
    logic         upd;
    logic [3:0]   btn_raw, btn_eff;

    assign btn_raw = {Up, Down, Left, Right};

    // ---------------- frame FSM: one position update per vertical blank ----------------
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) state <= WAIT_FRAME;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FRAME:  if ({1'b0, Val_Row_In} >= V_LIM) state_nxt = UPDATE;
            UPDATE:      state_nxt = WAIT_ACTIVE;
            WAIT_ACTIVE: if ({1'b0, Val_Row_In} < V_LIM) state_nxt = WAIT_FRAME;
            default:     state_nxt = WAIT_FRAME;
        endcase
    end

    always_comb begin
        upd = (state == UPDATE);
    end

    assign Frame_Tick_Out = upd;

`ifdef VGA_SPRITE_BTN_SYNC_EN
    logic [3:0] btn_s1, btn_s2, btn_prev;

    // A press only counts once it has been seen in two consecutive updates.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            if (upd) btn_prev <= btn_s2;
        end
    end

    assign btn_eff = btn_s2 & btn_prev;
`else
    assign btn_eff = btn_raw;
`endif

    // ---------------- movement and orientation ----------------
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                             input logic dec, input logic signed [10:0] max_v);
        logic signed [10:0] sum;
        sum = $signed({1'b0, pos});
        if (inc && !dec)      sum = sum + STEP_S;
        else if (dec && !inc) sum = sum - STEP_S;
        if (WRAP_EN != 0) begin
            if (sum > max_v)       sum = '0;
            else if (sum < 11'sd0) sum = max_v;
        end else begin
            if (sum > max_v)       sum = max_v;
            else if (sum < 11'sd0) sum = '0;
        end
        return sum[9:0];
    endfunction

    always_comb begin
        x_nxt   = step_axis(x_pos, btn_eff[0], btn_eff[1], MAX_X);
        y_nxt   = step_axis(y_pos, btn_eff[2], btn_eff[3], MAX_Y);
        dir_nxt = dir;
        if (btn_eff[3])      dir_nxt = DIR_UP;
        else if (btn_eff[2]) dir_nxt = DIR_DOWN;
        else if (btn_eff[1]) dir_nxt = DIR_LEFT;
        else if (btn_eff[0]) dir_nxt = DIR_RIGHT;
    end

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            x_pos <= X_INIT;
            y_pos <= Y_INIT;
            dir   <= DIR_UP;
        end else if (upd) begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
            dir   <= dir_nxt;
        end
    end

    assign X_Pos_Out = x_pos;
    assign Y_Pos_Out = y_pos;

    // ---------------- pixel stage 0: sprite-relative coordinate and ROM address ----------------
    logic signed [10:0] dx, dy, u_c, v_c;
    logic               active_c, inside_c;
    logic [ADDR_W-1:0]  u_a, v_a, addr_c;

    always_comb begin
        dx       = $signed({1'b0, Val_Col_In}) - $signed({1'b0, x_pos});
        dy       = $signed({1'b0, Val_Row_In}) - $signed({1'b0, y_pos});
        active_c = Disp_Ena_In && ({1'b0, Val_Col_In} < H_LIM) && ({1'b0, Val_Row_In} < V_LIM);
        inside_c = active_c && (dx >= 11'sd0) && (dx < SPR_S) && (dy >= 11'sd0) && (dy < SPR_S);
        u_c      = dx;
        v_c      = dy;
        // Rotation is a read-side remap of the unrotated ROM image.
        case (dir)
            DIR_DOWN: begin
                u_c = S_MAX - dx;
                v_c = S_MAX - dy;
            end
            DIR_RIGHT: begin
                u_c = S_MAX - dy;
                v_c = dx;
            end
            DIR_LEFT: begin
                u_c = dy;
                v_c = S_MAX - dx;
            end
            default: begin
                u_c = dx;
                v_c = dy;
            end
        endcase
        u_a    = ADDR_W'(u_c);
        v_a    = ADDR_W'(v_c);
        addr_c = v_a * ADDR_W'(SPR_SIZE) + u_a;
    end

    logic active_s0, inside_s0, active_s1, inside_s1;

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            Rom_Addr_Out <= '0;
            active_s0    <= 1'b0;
            inside_s0    <= 1'b0;
            active_s1    <= 1'b0;
            inside_s1    <= 1'b0;
        end else begin
            if (inside_c) Rom_Addr_Out <= addr_c;
            active_s0 <= active_c;
            inside_s0 <= inside_c;
            active_s1 <= active_s0;
            inside_s1 <= inside_s0;
        end
    end

    // ---------------- pixel stage 1: flags aligned with ROM data select the colour ----------------
    logic [11:0] pix;
    logic        hit;

    always_comb begin
        pix = 12'h000;
        hit = 1'b0;
        if (active_s1) begin
            if (inside_s1 && (Rom_Data_In != TRANS_KEY)) begin
                pix = Rom_Data_In;
                hit = 1'b1;
            end else begin
                pix = BG_COLOUR;
            end
        end
    end

    assign Red            = pix[11:8];
    assign Green          = pix[7:4];
    assign Blue           = pix[3:0];
    assign Sprite_Hit_Out = hit;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: clamp and wrap instances, behavioural position/orientation model,
// pixel scoreboard against a synchronous ROM whose contents are a known function of address.
module tb_vga_sprite_engine;
    logic        Master_Clock_In;
    logic        Reset_N_In;
    logic        Disp_Ena_In;
    logic [9:0]  Val_Col_In, Val_Row_In;
    logic        Up, Down, Left, Right;
    logic [9:0]  rom_addr, rom_addr_w;
    logic [11:0] rom_q;
    logic [3:0]  Red, Green, Blue, red_w, green_w, blue_w;
    logic        Sprite_Hit_Out, hit_w;
    logic [9:0]  X_Pos_Out, Y_Pos_Out, x_pos_w, y_pos_w;
    logic        Frame_Tick_Out, tick_w;
    logic        rom_trans;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;

    // model state
    int         mx, my, mxw, mdir;
    logic [3:0] mprev;
    logic [12:0] exp_q[$];

    vga_sprite_engine dut (
        .Master_Clock_In(Master_Clock_In), .Reset_N_In(Reset_N_In), .Disp_Ena_In(Disp_Ena_In),
        .Val_Col_In(Val_Col_In), .Val_Row_In(Val_Row_In),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right),
        .Rom_Addr_Out(rom_addr), .Rom_Data_In(rom_q),
        .Red(Red), .Green(Green), .Blue(Blue), .Sprite_Hit_Out(Sprite_Hit_Out),
        .X_Pos_Out(X_Pos_Out), .Y_Pos_Out(Y_Pos_Out), .Frame_Tick_Out(Frame_Tick_Out)
    );

    vga_sprite_engine #(.WRAP_EN(1)) dut_w (
        .Master_Clock_In(Master_Clock_In), .Reset_N_In(Reset_N_In), .Disp_Ena_In(Disp_Ena_In),
        .Val_Col_In(Val_Col_In), .Val_Row_In(Val_Row_In),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right),
        .Rom_Addr_Out(rom_addr_w), .Rom_Data_In(rom_q),
        .Red(red_w), .Green(green_w), .Blue(blue_w), .Sprite_Hit_Out(hit_w),
        .X_Pos_Out(x_pos_w), .Y_Pos_Out(y_pos_w), .Frame_Tick_Out(tick_w)
    );

    initial Master_Clock_In = 1'b0;
    always #5 Master_Clock_In = ~Master_Clock_In;

    function automatic logic [11:0] rom_fn(input logic [9:0] a);
        return 12'h100 + {2'b00, a};
    endfunction

    always @(posedge Master_Clock_In) rom_q <= rom_trans ? 12'hF0F : rom_fn(rom_addr);

    always @(negedge Master_Clock_In) if (Frame_Tick_Out === 1'b1) tick_cnt = tick_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int mv(input int p, input logic inc, input logic dec, input int maxv, input bit wrap);
        int s;
        s = p;
        if (inc && !dec)      s = s + 2;
        else if (dec && !inc) s = s - 2;
        if (wrap) begin
            if (s > maxv)   s = 0;
            else if (s < 0) s = maxv;
        end else begin
            if (s > maxv)   s = maxv;
            else if (s < 0) s = 0;
        end
        return s;
    endfunction

    task automatic model_reset();
        mx = 304; my = 224; mxw = 304; mdir = 0; mprev = 4'b0000;
    endtask

    // b = {Up, Down, Left, Right}
    task automatic model_update(input logic [3:0] b);
        logic [3:0] e;
`ifdef VGA_SPRITE_BTN_SYNC_EN
        e = b & mprev;
        mprev = b;
`else
        e = b;
`endif
        my  = mv(my, e[2], e[3], 448, 1'b0);
        mx  = mv(mx, e[0], e[1], 608, 1'b0);
        mxw = mv(mxw, e[0], e[1], 608, 1'b1);
        if (e[3])      mdir = 0;
        else if (e[2]) mdir = 1;
        else if (e[1]) mdir = 2;
        else if (e[0]) mdir = 3;
    endtask

    function automatic int exp_addr(input int col, input int row);
        int dx, dy, u, v;
        dx = col - mx; dy = row - my;
        case (mdir)
            1:       begin u = 31 - dx; v = 31 - dy; end
            2:       begin u = dy;      v = 31 - dx; end
            3:       begin u = 31 - dy; v = dx;      end
            default: begin u = dx;      v = dy;      end
        endcase
        return v * 32 + u;
    endfunction

    function automatic logic [12:0] exp_pix(input int col, input int row, input logic disp);
        int dx, dy;
        logic [11:0] c;
        if (!(disp && col < 640 && row < 480)) return 13'h0000;
        dx = col - mx; dy = row - my;
        if (dx < 0 || dx > 31 || dy < 0 || dy > 31) return {1'b0, 12'hFFF};
        c = rom_trans ? 12'hF0F : rom_fn(10'(exp_addr(col, row)));
        if (c == 12'hF0F) return {1'b0, 12'hFFF};
        return {1'b1, c};
    endfunction

    // Presents one coordinate at a negedge and scores the colour two clocks later.
    task automatic pixel(input string tag, input int col, input int row, input logic disp, input bit chk_addr);
        logic [12:0] e;
        int ea;
        Val_Col_In  = 10'(col);
        Val_Row_In  = 10'(row);
        Disp_Ena_In = disp;
        exp_q.push_back(exp_pix(col, row, disp));
        ea = exp_addr(col, row);
        @(posedge Master_Clock_In); #1;
        if (chk_addr) check_val({tag, "_addr"}, 32'(rom_addr), ea);
        @(posedge Master_Clock_In); #1;
        e = exp_q.pop_front();
        check_val({tag, "_rgb"}, {20'h0, Red, Green, Blue}, {20'h0, e[11:0]});
        check_val({tag, "_hit"}, 32'(Sprite_Hit_Out), 32'(e[12]));
        @(negedge Master_Clock_In);
        Disp_Ena_In = 1'b0;
    endtask

    task automatic run_frame(input logic [3:0] b);
        int t0;
        {Up, Down, Left, Right} = b;
        Disp_Ena_In = 1'b0; Val_Col_In = '0; Val_Row_In = '0;
        repeat (3) @(negedge Master_Clock_In);
        t0 = tick_cnt;
        Val_Row_In = 10'd480;
        repeat (4) @(negedge Master_Clock_In);
        Val_Row_In = 10'd0;
        repeat (2) @(negedge Master_Clock_In);
        model_update(b);
        check_val("frame_tick", 32'(tick_cnt - t0), 32'd1);
        check_val("x_pos", 32'(X_Pos_Out), mx);
        check_val("y_pos", 32'(Y_Pos_Out), my);
        check_val("x_pos_wrap", 32'(x_pos_w), mxw);
    endtask

    initial begin
        int x_before;
        Reset_N_In = 1'b0; Disp_Ena_In = 1'b0; Val_Col_In = '0; Val_Row_In = '0;
        {Up, Down, Left, Right} = 4'b0000; rom_trans = 1'b0;
        model_reset();
        repeat (3) @(negedge Master_Clock_In);
        check_val("rst_rgb", {20'h0, Red, Green, Blue}, 32'h0);
        check_val("rst_hit", 32'(Sprite_Hit_Out), 32'h0);
        check_val("rst_addr", 32'(rom_addr), 32'h0);
        check_val("rst_tick", 32'(Frame_Tick_Out), 32'h0);
        check_val("rst_x", 32'(X_Pos_Out), 32'd304);
        check_val("rst_y", 32'(Y_Pos_Out), 32'd224);
        Reset_N_In = 1'b1;
        @(negedge Master_Clock_In);

        run_frame(4'b0000);
        check_val("idle_x", 32'(X_Pos_Out), 32'd304);
        pixel("origin_up", 304, 224, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) run_frame(4'b0001);
        pixel("right_origin", mx, my, 1'b1, 1'b1);
        pixel("bg", 10, 10, 1'b1, 1'b0);
        pixel("inner", mx + 6, my + 6, 1'b1, 1'b1);

        run_frame(4'b1100);
        pixel("updown_origin", mx, my, 1'b1, 1'b1);
        run_frame(4'b0100);
        run_frame(4'b0100);
        pixel("down_origin", mx, my, 1'b1, 1'b1);
        pixel("down_far", mx + 31, my + 31, 1'b1, 1'b1);
        run_frame(4'b0010);
        pixel("left_a", mx + 1, my, 1'b1, 1'b1);
        pixel("left_b", mx + 5, my + 3, 1'b1, 1'b1);
        run_frame(4'b0001);
        pixel("rightdir", mx + 1, my, 1'b1, 1'b1);

        rom_trans = 1'b1;
        pixel("trans", mx + 2, my + 2, 1'b1, 1'b0);
        rom_trans = 1'b0;
        pixel("disp_off", mx + 2, my + 2, 1'b0, 1'b0);
        pixel("col_oob", 650, 10, 1'b1, 1'b0);

        for (int i = 0; i < 400 && mx > 2; i++) run_frame(4'b0010);
        check_val("at_x2", 32'(X_Pos_Out), 32'd2);
        for (int i = 0; i < 3; i++) run_frame(4'b0010);
        check_val("clamp_x", 32'(X_Pos_Out), 32'd0);

        // Reset during active video with a sprite pixel on screen and a button held.
        {Up, Down, Left, Right} = 4'b0001;
        Val_Col_In = 10'(mx + 1); Val_Row_In = 10'(my + 1); Disp_Ena_In = 1'b1;
        repeat (3) @(negedge Master_Clock_In);
        check_val("pre_rst_hit", 32'(Sprite_Hit_Out), 32'(exp_pix(mx + 1, my + 1, 1'b1) >> 12));
        Reset_N_In = 1'b0;
        #1;
        check_val("midrst_rgb", {20'h0, Red, Green, Blue}, 32'h0);
        check_val("midrst_hit", 32'(Sprite_Hit_Out), 32'h0);
        check_val("midrst_addr", 32'(rom_addr), 32'h0);
        check_val("midrst_x", 32'(X_Pos_Out), 32'd304);
        check_val("midrst_y", 32'(Y_Pos_Out), 32'd224);
        @(negedge Master_Clock_In);
        Disp_Ena_In = 1'b0; Val_Row_In = '0;
        model_reset();
        Reset_N_In = 1'b1;
        @(negedge Master_Clock_In);
        run_frame(4'b0000);
        pixel("post_rst", 304, 224, 1'b1, 1'b1);

        x_before = mx;
        run_frame(4'b0001);
        run_frame(4'b0000);
`ifdef VGA_SPRITE_BTN_SYNC_EN
        check_val("one_frame_press", 32'(X_Pos_Out), 32'(x_before));
`else
        check_val("one_frame_press", 32'(X_Pos_Out), 32'(x_before + 2));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised successor to the single-box VGA draw block.
- Renders one movable, rotatable sprite over a flat background.
- Sprite pixels come from an external synchronous sprite ROM (1-cycle read latency); movement is updated exactly once per frame from four direction buttons.
- Sits between the VGA timing generator (Disp_Ena_In, Val_Col_In, Val_Row_In) and the 4-bit RGB DAC pins.

Parameters:
- H_PIXELS, 640, active columns
- V_PIXELS, 480, active rows
- SPR_SIZE, 32, sprite width = height in pixels (square; required for 90° rotation)
- STEP, 2, pixels moved per frame per pressed axis
- WRAP_EN, 0, edge mode: 0 = clamp at screen edge, 1 = wrap to opposite edge
- BG_COLOUR, 12'hFFF, background {R,G,B}
- TRANS_KEY, 12'hF0F, ROM colour treated as transparent
- ADDR_W, 10, ROM address width, ≥ clog2(SPR_SIZE*SPR_SIZE)

Ports:
- Master_Clock_In  in  1  pixel/system clock
- Reset_N_In  in  1  asynchronous active-low reset
- Disp_Ena_In  in  1  active video from timing generator
- Val_Col_In  in  10  current column (horizontal)
- Val_Row_In  in  10  current row (vertical)
- Up, Down, Left, Right  in  1 each  direction buttons, active high
- Rom_Addr_Out  out  ADDR_W  sprite ROM address
- Rom_Data_In  in  12  ROM colour {R[11:8],G[7:4],B[3:0]}, valid 1 clock after address
- Red, Green, Blue  out  4 each  pixel colour
- Sprite_Hit_Out  out  1  current output pixel is an opaque sprite pixel
- X_Pos_Out, Y_Pos_Out  out  10 each  sprite top-left position
- Frame_Tick_Out  out  1  one-clock pulse when position is updated

Behaviour:
- Reset (async, Reset_N_In=0):
  - RGB = 0, Sprite_Hit_Out = 0, Rom_Addr_Out = 0, Frame_Tick_Out = 0.
  - X = (H_PIXELS−SPR_SIZE)/2, Y = (V_PIXELS−SPR_SIZE)/2, DIR = UP, FSM = WAIT_FRAME.
  - Reset mid-frame takes effect immediately; the next update follows the next frame-tick condition.
- Frame FSM:
  - WAIT_FRAME: go to UPDATE when Val_Row_In ≥ V_PIXELS (vertical blanking).
  - UPDATE (1 clock): apply movement, pulse Frame_Tick_Out, go to WAIT_ACTIVE.
  - WAIT_ACTIVE: go to WAIT_FRAME when Val_Row_In < V_PIXELS.
  - Guarantees exactly one update per frame regardless of the clock/pixel ratio.
- Movement (sampled in UPDATE):
  - Up: Y−STEP. Down: Y+STEP. Left: X−STEP. Right: X+STEP.
  - Opposing pair both high: that axis does not move. Diagonal motion is allowed.
  - MAX_X = H_PIXELS−SPR_SIZE, MAX_Y = V_PIXELS−SPR_SIZE.
  - Clamp (WRAP_EN=0): result saturates to [0, MAX]. Compute in 11-bit signed to avoid underflow.
  - Wrap (WRAP_EN=1): a move past MAX gives 0; a move below 0 gives MAX.
- Orientation DIR:
  - Priority Up > Down > Left > Right among pressed buttons; holds when no button is pressed.
  - Updated in UPDATE only.
- Pixel pipeline (2 clocks, coordinates to RGB):
  - Stage 0: dx = Col−X, dy = Row−Y. Inside = Disp_Ena_In & Col<H_PIXELS & Row<V_PIXELS & 0≤dx<SPR_SIZE & 0≤dy<SPR_SIZE.
  - Stage 0 ROM coordinate (u,v) by DIR, with S = SPR_SIZE−1:
    - UP: (dx, dy)
    - DOWN: (S−dx, S−dy)
    - RIGHT: (S−dy, dx)
    - LEFT: (dy, S−dx)
  - Stage 0 register: Rom_Addr_Out = v*SPR_SIZE+u, plus delayed inside/active flags.
  - Stage 1: if not active → RGB 0, hit 0. Else if inside and Rom_Data_In ≠ TRANS_KEY → ROM colour, hit 1. Else → BG_COLOUR, hit 0.
  - Not-inside pixels leave Rom_Addr_Out unchanged (don't-care) and never select ROM data.
- Position changes occur only in blanking, so no tearing.

Optional Feature:
- Macro: VGA_SPRITE_BTN_SYNC_EN
- Defined:
  - Each button passes through a 2-flop synchroniser.
  - The button must read high in two consecutive UPDATE cycles to count as pressed; the first frame of a press produces no motion.
- Undefined:
  - Buttons are sampled raw in UPDATE; a press counts in its first frame.

Test Plan:
- Reset, run one frame with no buttons → X=304, Y=224, DIR=UP. Exactly one Frame_Tick_Out pulse per frame.
- Hold Right for 10 frames → X=324. Pixel (Col=324,Row=224) shows ROM[0] when ROM[0]≠TRANS_KEY, 2 clocks after coordinates are presented.
- WRAP_EN=0: from X=2, hold Left 3 frames → X=0, 0, 0. WRAP_EN=1: from X=2, hold Left 2 frames → X=0, then X=608.
- Up+Down held together → Y unchanged, DIR=UP. Down alone → DIR=DOWN; at sprite origin, Rom_Addr_Out = 1023 (SPR_SIZE=32).
- ROM returns 12'hF0F inside sprite → RGB = F,F,F, Sprite_Hit_Out=0. Disp_Ena_In=0 → RGB = 0,0,0.
- Assert reset mid-frame during a move → outputs zero immediately, position returns to centre. With VGA_SPRITE_BTN_SYNC_EN, a 1-frame Right press leaves X unchanged.
